// File: rtl/roi_downsampler.sv
// Box-averages a centred ROI of the pixel stream into an OUT_DIM x OUT_DIM image, one block-row of accumulators.
// Build option: INVERT_EN outputs 252 - average (bright stroke on black) instead of the plain average.
module roi_downsampler #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ROI_X0     = 96,
    parameter int ROI_Y0     = 16,
    parameter int BLOCK_LOG2 = 4,
    parameter int OUT_DIM    = 28
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       pix_valid,
    input  logic [5:0] pix_data,
    output logic [9:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_we,
    output logic       frame_done
);

    localparam int IDX_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    // Block sum scaled so a full-scale block (63 per pixel) maps to 252.
    localparam int AVG_SHIFT = 2 * BLOCK_LOG2 - 2;
    localparam logic [9:0] X_LAST    = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] Y_END     = 10'(IMG_HEIGHT);
    localparam logic [9:0] X0        = 10'(ROI_X0);
    localparam logic [9:0] Y0        = 10'(ROI_Y0);
    localparam logic [9:0] ROI_SPAN  = 10'(OUT_DIM << BLOCK_LOG2);
    localparam logic [9:0] ADDR_LAST = 10'(OUT_DIM * OUT_DIM - 1);

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_frame_ok;
    logic [13:0] r_acc [OUT_DIM];

    logic [9:0]       w_lx;
    logic [9:0]       w_ly;
    logic [9:0]       w_bx;
    logic [9:0]       w_by;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_roi;
    logic             w_accept;
    logic             w_blk_end;
    logic [13:0]      w_sum;
    logic [7:0]       w_avg;
    logic [7:0]       w_out_data;
    logic [9:0]       w_row_base;
    logic [9:0]       w_addr;

    // Unsigned wrap makes columns/lines left of or above the ROI compare as large.
    assign w_lx      = r_x - X0;
    assign w_ly      = r_y - Y0;
    assign w_in_roi  = (w_lx < ROI_SPAN) && (w_ly < ROI_SPAN) && (r_y < Y_END);
    assign w_bx      = w_lx >> BLOCK_LOG2;
    assign w_by      = w_ly >> BLOCK_LOG2;
    assign w_idx     = IDX_W'(w_bx);
    assign w_accept  = pix_valid && !vsync && r_frame_ok && w_in_roi;
    assign w_blk_end = (&w_lx[BLOCK_LOG2-1:0]) && (&w_ly[BLOCK_LOG2-1:0]);
    assign w_sum     = r_acc[w_idx] + {8'd0, pix_data};
    assign w_avg     = 8'(w_sum >> AVG_SHIFT);

`ifdef INVERT_EN
    assign w_out_data = 8'd252 - w_avg;
`else
    assign w_out_data = w_avg;
`endif

    generate
        if (OUT_DIM == 28) begin : g_row_shift
            assign w_row_base = (w_by << 5) - (w_by << 2);
        end else begin : g_row_mult
            assign w_row_base = w_by * 10'(OUT_DIM);
        end
    endgenerate

    assign w_addr = w_row_base + w_bx;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_frame_ok <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_we     <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < OUT_DIM; i++) r_acc[i] <= '0;
        end else begin
            out_we     <= 1'b0;
            frame_done <= 1'b0;
            if (vsync) begin
                r_x        <= '0;
                r_y        <= '0;
                r_frame_ok <= 1'b1;
                for (int i = 0; i < OUT_DIM; i++) r_acc[i] <= '0;
            end else if (pix_valid) begin
                if (r_y < Y_END) begin
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + 10'd1;
                    end else begin
                        r_x <= r_x + 10'd1;
                    end
                end
                if (w_accept) begin
                    if (w_blk_end) begin
                        r_acc[w_idx] <= '0;
                        out_we       <= 1'b1;
                        out_addr     <= w_addr;
                        out_data     <= w_out_data;
                        if (w_addr == ADDR_LAST) begin
                            frame_done <= 1'b1;
                            r_frame_ok <= 1'b0;
                        end
                    end else begin
                        r_acc[w_idx] <= w_sum;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_roi_downsampler.sv
// Self-checking bench for roi_downsampler on a scaled geometry (24x20 frame, 16x16 ROI, 4x4 blocks).
// Honours INVERT_EN the same way as the design build.
module tb_roi_downsampler;

    localparam int W    = 24;
    localparam int H    = 20;
    localparam int X0   = 4;
    localparam int Y0   = 2;
    localparam int BL   = 2;
    localparam int D    = 4;
    localparam int BLK  = 1 << BL;
    localparam int ROI  = D * BLK;
    localparam int NOUT = D * D;

    logic       pclk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       pix_valid;
    logic [5:0] pix_data;
    logic [9:0] out_addr;
    logic [7:0] out_data;
    logic       out_we;
    logic       frame_done;

    roi_downsampler #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ROI_X0(X0), .ROI_Y0(Y0),
        .BLOCK_LOG2(BL), .OUT_DIM(D)
    ) dut (
        .pclk(pclk), .reset(reset), .vsync(vsync), .pix_valid(pix_valid),
        .pix_data(pix_data), .out_addr(out_addr), .out_data(out_data),
        .out_we(out_we), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        bit fd;
        int cyc;
    } obs_t;

    obs_t obs[$];
    int   fd_cnt = 0;

    always @(negedge pclk) begin
        if (out_we) obs.push_back('{int'(out_addr), int'(out_data), frame_done, cyc});
        if (frame_done) fd_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int img [H][W];
    int last_pix_cyc;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int pol(input int v);
`ifdef INVERT_EN
        return 252 - v;
`else
        return v;
`endif
    endfunction

    // mode 0: uniform a; 1: ROI interior a, surround b; 2: bottom-right block a, rest b; 3: random
    function automatic void fill(input int mode, input int a, input int b);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                bit in_roi, in_last;
                in_roi  = (x >= X0) && (x < X0 + ROI) && (y >= Y0) && (y < Y0 + ROI);
                in_last = (x >= X0 + ROI - BLK) && (x < X0 + ROI) &&
                          (y >= Y0 + ROI - BLK) && (y < Y0 + ROI);
                case (mode)
                    0:       img[y][x] = a;
                    1:       img[y][x] = in_roi ? a : b;
                    2:       img[y][x] = in_last ? a : b;
                    default: img[y][x] = int'($urandom_range(0, 63));
                endcase
            end
    endfunction

    // Reference: each output is 4x the block mean, truncated.
    function automatic void model(output int ev [NOUT]);
        for (int by = 0; by < D; by++)
            for (int bx = 0; bx < D; bx++) begin
                int s;
                s = 0;
                for (int j = 0; j < BLK; j++)
                    for (int i = 0; i < BLK; i++)
                        s += img[Y0 + by * BLK + j][X0 + bx * BLK + i];
                ev[by * D + bx] = pol((s * 4) / (BLK * BLK));
            end
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Optional vsync (with pixel strobes that must be dropped), then n_lines of img in raster order.
    task automatic drive_frame(input bit do_vsync, input int n_lines);
        if (do_vsync) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                vsync     = 1'b1;
                pix_valid = 1'b1;
                pix_data  = 6'($urandom_range(0, 63));
            end
        end
        tick();
        vsync     = 1'b0;
        pix_valid = 1'b0;
        for (int y = 0; y < n_lines; y++)
            for (int x = 0; x < W; x++) begin
                tick();
                pix_valid = 1'b1;
                pix_data  = (y < H) ? 6'(img[y][x]) : 6'd63;
                if (y == Y0 + ROI - 1 && x == X0 + ROI - 1) last_pix_cyc = cyc;
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    pix_valid = 1'b0;
                end
            end
        tick();
        pix_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_frame(input string tag, input int base, input int fd_base,
                               input int ev [NOUT], input bit chk_latency);
        int n, fds;
        n = obs.size() - base;
        check({tag, " we_count"}, n, NOUT);
        check({tag, " frame_done_count"}, fd_cnt - fd_base, 1);
        if (n == NOUT) begin
            fds = 0;
            for (int i = 0; i < NOUT; i++) begin
                check($sformatf("%s addr[%0d]", tag, i), obs[base + i].addr, i);
                check($sformatf("%s data[%0d]", tag, i), obs[base + i].data, ev[i]);
                fds += int'(obs[base + i].fd);
            end
            check({tag, " done_on_last"}, int'(obs[base + NOUT - 1].fd), 1);
            check({tag, " done_only_once"}, fds, 1);
            if (chk_latency)
                check({tag, " done_latency"}, obs[base + NOUT - 1].cyc - last_pix_cyc, 1);
        end
    endtask

    typedef struct {
        string name;
        int    mode;
        int    a;
        int    b;
        int    exp_body;
        int    exp_last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int ev [NOUT];
        int base, fd_base;

        vecs[0] = '{"uniform32",  0, 32, 0,  128, 128};
        vecs[1] = '{"roi_border", 1, 0,  63, 0,   0};
        vecs[2] = '{"last_block", 2, 63, 0,  0,   252};
        vecs[3] = '{"uniform0",   0, 0,  0,  0,   0};
        vecs[4] = '{"uniform63",  0, 63, 0,  252, 252};

        reset     = 1'b1;
        vsync     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        repeat (3) tick();
        check("reset out_addr", int'(out_addr), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset out_we", int'(out_we), 0);
        check("reset frame_done", int'(frame_done), 0);
        reset = 1'b0;

        // First frame after reset has no vsync and must produce nothing.
        fill(0, 32, 0);
        base = obs.size(); fd_base = fd_cnt;
        drive_frame(1'b0, H);
        check("no_vsync we_count", obs.size() - base, 0);
        check("no_vsync done_count", fd_cnt - fd_base, 0);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].mode, vecs[v].a, vecs[v].b);
            for (int i = 0; i < NOUT; i++)
                ev[i] = pol((i == NOUT - 1) ? vecs[v].exp_last : vecs[v].exp_body);
            base = obs.size(); fd_base = fd_cnt;
            drive_frame(1'b1, H + 2);
            check_frame(vecs[v].name, base, fd_base, ev, 1'b1);
        end

        // vsync mid-frame abandons a uniform-40 frame partway through a block-row.
        fill(0, 40, 0);
        fd_base = fd_cnt;
        drive_frame(1'b1, 12);
        check("abort no_frame_done", fd_cnt - fd_base, 0);
        fill(0, 10, 0);
        for (int i = 0; i < NOUT; i++) ev[i] = pol(40);
        base = obs.size(); fd_base = fd_cnt;
        drive_frame(1'b1, H);
        check_frame("after_abort", base, fd_base, ev, 1'b1);

        // Reset mid-frame, then a vsync-less frame (silent), then a clean frame.
        fill(0, 63, 0);
        drive_frame(1'b1, 10);
        tick();
        reset = 1'b1;
        tick();
        check("midreset out_addr", int'(out_addr), 0);
        check("midreset out_data", int'(out_data), 0);
        check("midreset out_we", int'(out_we), 0);
        check("midreset frame_done", int'(frame_done), 0);
        tick();
        reset = 1'b0;
        base = obs.size(); fd_base = fd_cnt;
        drive_frame(1'b0, H);
        check("post_reset we_count", obs.size() - base, 0);
        check("post_reset done_count", fd_cnt - fd_base, 0);
        for (int i = 0; i < NOUT; i++) ev[i] = pol(252);
        base = obs.size(); fd_base = fd_cnt;
        drive_frame(1'b1, H);
        check_frame("post_reset63", base, fd_base, ev, 1'b1);

        // Random images against the block-mean model.
        for (int r = 0; r < 4; r++) begin
            fill(3, 0, 0);
            model(ev);
            base = obs.size(); fd_base = fd_cnt;
            drive_frame(1'b1, H);
            check_frame($sformatf("random%0d", r), base, fd_base, ev, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
